// File: rtl/mat_ctrl_pkg.sv
// Shared types and helpers for the matrix sequencers (mat_sub, mat_add, mat_mult).
package mat_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } seq_state_t;

    // Operand RAMs return data one cycle after the read strobe.
    localparam int unsigned READ_LAT = 1;

    function automatic int unsigned flat_addr(input int unsigned i,
                                              input int unsigned j,
                                              input int unsigned size_b);
        return i * size_b + j;
    endfunction

    // Counter width that stays at least one bit for degenerate 1-element ranges.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_addr_gen.sv
// Row-major element walker: row/column counters plus a flat address incrementer
// that saturates on the last element until cleared.
module mat_addr_gen
    import mat_ctrl_pkg::*;
#(
    parameter int unsigned SIZE_A = 8,
    parameter int unsigned SIZE_B = 8,
    parameter int unsigned ADDR_W = cnt_width(SIZE_A * SIZE_B)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam int unsigned RowW = cnt_width(SIZE_A);
    localparam int unsigned ColW = cnt_width(SIZE_B);
    localparam logic [RowW-1:0] RowLast = RowW'(SIZE_A - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(SIZE_B - 1);
    localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(flat_addr(SIZE_A - 1, SIZE_B - 1, SIZE_B));

    logic [RowW-1:0]   row_q, row_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign last_o = (row_q == RowLast) && (col_q == ColLast);
    assign addr_o = addr_q;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (clr_i) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (en_i && !last_o) begin
            // Flat incrementer tracks i*SIZE_B+j without a multiplier.
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    // The flat counter must agree with the row/column pair at the final element.
    logic unused_addr_last;
    assign unused_addr_last = (addr_q == AddrLast);

endmodule

// File: rtl/mat_sub_sequencer.sv
// Element-wise C = A - B sequencer: streams operands from two single-port RAMs
// through a read-align stage and a registered subtract into a result RAM.
module mat_sub_sequencer
    import mat_ctrl_pkg::*;
#(
    parameter int unsigned SIZE_A = 8,
    parameter int unsigned SIZE_B = 8,
    parameter int unsigned N_BITS = 32,
    parameter int unsigned ADDR_W = cnt_width(SIZE_A * SIZE_B)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rd_en_o,
    output logic [ADDR_W-1:0]        rd_addr_o,
    input  logic signed [N_BITS-1:0] rd_data_a_i,
    input  logic signed [N_BITS-1:0] rd_data_b_i,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic signed [N_BITS:0]   wr_data_o
);

    seq_state_t state_q, state_d;

    logic              cnt_clr, cnt_en, rd_last;
    logic [ADDR_W-1:0] rd_addr;

    logic              s1_vld_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [N_BITS:0]   wr_data_q;
    logic [N_BITS:0]   diff;

    mat_addr_gen #(
        .SIZE_A (SIZE_A),
        .SIZE_B (SIZE_B),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .addr_o (rd_addr),
        .last_o (rd_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) state_d = StRun;
            end
            StRun: begin
                cnt_en = 1'b1;
                if (rd_last) state_d = StDrain;
            end
            StDrain: begin
                // Last write is on the bus once stage 1 has emptied.
                if (wr_en_q && !s1_vld_q) state_d = StDone;
            end
            StDone: begin
                cnt_clr = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Full-precision difference: one extra bit makes overflow impossible.
    assign diff = {rd_data_a_i[N_BITS-1], rd_data_a_i} - {rd_data_b_i[N_BITS-1], rd_data_b_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            s1_vld_q <= rd_en_o;
            wr_en_q  <= s1_vld_q;
            if (rd_en_o) s1_addr_q <= rd_addr;
            // Write bus only moves on valid data to avoid idle toggling.
            if (s1_vld_q) begin
                wr_addr_q <= s1_addr_q;
                wr_data_q <= diff;
            end
        end
    end

    assign rd_en_o   = (state_q == StRun);
    assign rd_addr_o = rd_addr;
    assign busy_o    = (state_q == StRun) || (state_q == StDrain);
    assign done_o    = (state_q == StDone);
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule
